// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the three-port SDRAM command arbiter: port indices,
// FSM state encoding and the winner-selection rule.
package sdram_port_arbiter_pkg;

  localparam int NUM_PORTS = 3;

  localparam logic [1:0] PORT_CAM  = 2'd0;
  localparam logic [1:0] PORT_DISP = 2'd1;
  localparam logic [1:0] PORT_HDR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_WAIT_RD = 2'd2
  } arb_state_e;

  // Display has priority until its burst cap is hit while someone else waits;
  // camera and HDR share the remaining slots round-robin.
  function automatic logic [1:0] pickWinner(input logic [NUM_PORTS-1:0] pend,
                                            input logic dispCapped,
                                            input logic rrHdr);
    if (pend[PORT_DISP] && !(dispCapped && (pend[PORT_CAM] || pend[PORT_HDR])))
      return PORT_DISP;
    if (pend[PORT_CAM] && pend[PORT_HDR])
      return rrHdr ? PORT_HDR : PORT_CAM;
    if (pend[PORT_HDR])
      return PORT_HDR;
    return PORT_CAM;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_slot.sv
// One requester slot: latches a single request (address and optional data),
// holds it pending until the arbiter clears it, and records dropped pulses.
module sdram_port_slot
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              pending_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              overflow_o
);

  logic              pending_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              overflow_q;

  // A pulse arriving while the flag is still set (including its clearing cycle) is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (req_i && pending_q)
        overflow_q <= 1'b1;
      if (clr_i) begin
        pending_q <= 1'b0;
      end else if (req_i && !pending_q) begin
        pending_q <= 1'b1;
        addr_q    <= addr_i;
        data_q    <= data_i;
      end
    end
  end

  assign pending_o  = pending_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between the camera write path and
// the display / HDR read paths, routing read data back to the issuing port.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 25,
  parameter int DATA_W         = 256,
  parameter int DISP_MAX_BURST = 4,
  parameter int RD_TIMEOUT     = 255
) (
  input  logic              clk_133M,
  input  logic              rst_n_133M,
  input  logic              cam_wr_req,
  input  logic [ADDR_W-1:0] cam_address,
  input  logic [DATA_W-1:0] cam_data,
  output logic              cam_busy,
  input  logic              disp_rd_req,
  input  logic [ADDR_W-1:0] disp_address,
  output logic              disp_busy,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_data_valid,
  input  logic              hdr_rd_req,
  input  logic [ADDR_W-1:0] hdr_address,
  output logic              hdr_busy,
  output logic [DATA_W-1:0] hdr_data,
  output logic              hdr_data_valid,
  output logic              mem_cmd_valid,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        overflow,
  output logic              rd_timeout
);

  localparam logic [7:0] DISP_CAP = 8'(DISP_MAX_BURST);
  localparam logic [7:0] RD_LIMIT = 8'(RD_TIMEOUT);

  arb_state_e state_q;
  logic [1:0] grant_q;
  logic [1:0] winner_d;
  logic       rrHdr_q;
  logic [7:0] burst_q;
  logic [7:0] toCnt_q;
  logic [7:0] toCnt_d;

  logic [NUM_PORTS-1:0] reqVec;
  logic [NUM_PORTS-1:0] pendVec;
  logic [NUM_PORTS-1:0] clrVec;
  logic [NUM_PORTS-1:0] ovfVec;
  logic [ADDR_W-1:0]    inAddr   [NUM_PORTS];
  logic [ADDR_W-1:0]    slotAddr [NUM_PORTS];
  logic [DATA_W-1:0]    inData   [NUM_PORTS];
  logic [DATA_W-1:0]    slotData [NUM_PORTS];

  assign reqVec[PORT_CAM]  = cam_wr_req;
  assign reqVec[PORT_DISP] = disp_rd_req;
  assign reqVec[PORT_HDR]  = hdr_rd_req;
  assign inAddr[PORT_CAM]  = cam_address;
  assign inAddr[PORT_DISP] = disp_address;
  assign inAddr[PORT_HDR]  = hdr_address;
  assign inData[PORT_CAM]  = cam_data;
  assign inData[PORT_DISP] = '0;
  assign inData[PORT_HDR]  = '0;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : gSlot
    sdram_port_slot #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) uSlot (
      .clk_i     (clk_133M),
      .rst_ni    (rst_n_133M),
      .req_i     (reqVec[p]),
      .clr_i     (clrVec[p]),
      .addr_i    (inAddr[p]),
      .data_i    (inData[p]),
      .pending_o (pendVec[p]),
      .addr_o    (slotAddr[p]),
      .data_o    (slotData[p]),
      .overflow_o(ovfVec[p])
    );
  end

  assign cam_busy  = pendVec[PORT_CAM];
  assign disp_busy = pendVec[PORT_DISP];
  assign hdr_busy  = pendVec[PORT_HDR];
  assign overflow  = ovfVec;

  assign winner_d = pickWinner(pendVec, burst_q >= DISP_CAP, rrHdr_q);
  assign toCnt_d  = toCnt_q + 8'd1;

  // Pending flags drop on the same edge the FSM retires the owning transaction.
  always_comb begin
    clrVec = '0;
    case (state_q)
      ST_CMD:     if (mem_ready && mem_cmd_we) clrVec[grant_q] = 1'b1;
      ST_WAIT_RD: if (mem_rd_valid || toCnt_d == RD_LIMIT) clrVec[grant_q] = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      state_q         <= ST_IDLE;
      grant_q         <= PORT_CAM;
      rrHdr_q         <= 1'b0;
      burst_q         <= '0;
      toCnt_q         <= '0;
      mem_cmd_valid   <= 1'b0;
      mem_cmd_we      <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      disp_data       <= '0;
      disp_data_valid <= 1'b0;
      hdr_data        <= '0;
      hdr_data_valid  <= 1'b0;
      rd_timeout      <= 1'b0;
    end else begin
      disp_data_valid <= 1'b0;
      hdr_data_valid  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|pendVec) begin
            grant_q       <= winner_d;
            mem_cmd_we    <= (winner_d == PORT_CAM);
            mem_address   <= slotAddr[winner_d];
            mem_wdata     <= slotData[winner_d];
            mem_cmd_valid <= 1'b1;
            state_q       <= ST_CMD;
            if (winner_d == PORT_DISP) begin
              if (burst_q < DISP_CAP)
                burst_q <= burst_q + 8'd1;
            end else begin
              burst_q <= '0;
              rrHdr_q <= (winner_d == PORT_CAM);
            end
          end
        end
        ST_CMD: begin
          if (mem_ready) begin
            mem_cmd_valid <= 1'b0;
            toCnt_q       <= '0;
            state_q       <= mem_cmd_we ? ST_IDLE : ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          if (mem_rd_valid) begin
            if (grant_q == PORT_DISP) begin
              disp_data       <= mem_rdata;
              disp_data_valid <= 1'b1;
            end else if (grant_q == PORT_HDR) begin
              hdr_data       <= mem_rdata;
              hdr_data_valid <= 1'b1;
            end
            toCnt_q <= '0;
            state_q <= ST_IDLE;
          end else if (toCnt_d == RD_LIMIT) begin
            rd_timeout <= 1'b1;
            toCnt_q    <= '0;
            state_q    <= ST_IDLE;
          end else begin
            toCnt_q <= toCnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: a scoreboard of expected commands
// and read data, a small memory responder, a vector table and corner sequences.
module tb_sdram_port_arbiter;
  import sdram_port_arbiter_pkg::*;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 256;

  logic              clk_133M;
  logic              rst_n_133M;
  logic              cam_wr_req;
  logic [ADDR_W-1:0] cam_address;
  logic [DATA_W-1:0] cam_data;
  logic              cam_busy;
  logic              disp_rd_req;
  logic [ADDR_W-1:0] disp_address;
  logic              disp_busy;
  logic [DATA_W-1:0] disp_data;
  logic              disp_data_valid;
  logic              hdr_rd_req;
  logic [ADDR_W-1:0] hdr_address;
  logic              hdr_busy;
  logic [DATA_W-1:0] hdr_data;
  logic              hdr_data_valid;
  logic              mem_cmd_valid;
  logic              mem_cmd_we;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic [2:0]        overflow;
  logic              rd_timeout;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DISP_MAX_BURST(4), .RD_TIMEOUT(255)
  ) dut (
    .clk_133M(clk_133M), .rst_n_133M(rst_n_133M),
    .cam_wr_req(cam_wr_req), .cam_address(cam_address), .cam_data(cam_data),
    .cam_busy(cam_busy),
    .disp_rd_req(disp_rd_req), .disp_address(disp_address), .disp_busy(disp_busy),
    .disp_data(disp_data), .disp_data_valid(disp_data_valid),
    .hdr_rd_req(hdr_rd_req), .hdr_address(hdr_address), .hdr_busy(hdr_busy),
    .hdr_data(hdr_data), .hdr_data_valid(hdr_data_valid),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata),
    .overflow(overflow), .rd_timeout(rd_timeout)
  );

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
  } cmd_t;

  typedef struct {
    logic [1:0]        port;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    int                lat;
    logic              expWe;
    int                expBusy;
  } vec_t;

  cmd_t              cmdQ[$];
  logic [DATA_W-1:0] dispQ[$];
  logic [DATA_W-1:0] hdrQ[$];

  int checks = 0;
  int errors = 0;
  int hdrStrobes = 0;

  bit                respEnable = 1'b1;
  int                respLat = 1;
  bit                respArmed;
  int                respCnt;
  logic [DATA_W-1:0] respData;

  initial begin
    clk_133M = 1'b0;
    forever #5 clk_133M = ~clk_133M;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory side: monitor checks commands and read strobes at negedge; the
  // responder returns read data respLat cycles after each read handshake.
  initial begin
    cmd_t e;
    mem_rd_valid = 1'b0;
    mem_rdata    = '0;
    respArmed    = 1'b0;
    respCnt      = 0;
    respData     = '0;
    forever begin
      @(negedge clk_133M);
      if (rst_n_133M) begin
        if (mem_cmd_valid && mem_ready) begin
          if (cmdQ.size() == 0) begin
            checkOutput("unexpected_cmd", mem_address, '1);
          end else begin
            e = cmdQ.pop_front();
            checkOutput("cmd_we", mem_cmd_we, e.we);
            checkOutput("cmd_addr", mem_address, e.addr);
            if (e.we) checkOutput("cmd_wdata", mem_wdata, e.wdata);
            if (!mem_cmd_we && respEnable) begin
              respArmed = 1'b1;
              respCnt   = respLat - 1;
              respData  = e.rdata;
            end
          end
        end
        if (disp_data_valid) begin
          if (dispQ.size() == 0) checkOutput("unexpected_disp_valid", disp_data_valid, 1'b0);
          else checkOutput("disp_data", disp_data, dispQ.pop_front());
        end
        if (hdr_data_valid) begin
          hdrStrobes++;
          if (hdrQ.size() == 0) checkOutput("unexpected_hdr_valid", hdr_data_valid, 1'b0);
          else checkOutput("hdr_data", hdr_data, hdrQ.pop_front());
        end
      end
      @(posedge clk_133M);
      #1;
      mem_rd_valid = 1'b0;
      if (respArmed) begin
        if (respCnt == 0) begin
          mem_rd_valid = 1'b1;
          mem_rdata    = respData;
          respArmed    = 1'b0;
        end else begin
          respCnt--;
        end
      end
    end
  end

  // Pulses the masked request lines for one cycle; called and returns at posedge+1.
  task automatic applyStimulus(input logic [2:0] mask, input logic [ADDR_W-1:0] camA,
                               input logic [DATA_W-1:0] camD, input logic [ADDR_W-1:0] dispA,
                               input logic [ADDR_W-1:0] hdrA);
    cam_wr_req   = mask[PORT_CAM];
    cam_address  = camA;
    cam_data     = camD;
    disp_rd_req  = mask[PORT_DISP];
    disp_address = dispA;
    hdr_rd_req   = mask[PORT_HDR];
    hdr_address  = hdrA;
    @(posedge clk_133M);
    #1;
    cam_wr_req  = 1'b0;
    disp_rd_req = 1'b0;
    hdr_rd_req  = 1'b0;
  endtask

  task automatic pushCmd(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.rdata = rdata;
    cmdQ.push_back(c);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk_133M);
      n++;
    end while ((cam_busy || disp_busy || hdr_busy || mem_cmd_valid) && n < budget);
    checkOutput(name, {cam_busy, disp_busy, hdr_busy, mem_cmd_valid}, 4'b0000);
    @(posedge clk_133M);
    #1;
  endtask

  task automatic waitHandshake(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk_133M);
      n++;
    end while (!(mem_cmd_valid && mem_ready) && n < budget);
    checkOutput(name, mem_cmd_valid && mem_ready, 1'b1);
  endtask

  function automatic logic busyOf(input logic [1:0] p);
    if (p == PORT_CAM) return cam_busy;
    if (p == PORT_DISP) return disp_busy;
    return hdr_busy;
  endfunction

  initial begin
    vec_t vecs[5];
    int   cnt;
    int   strobesBefore;
    logic [DATA_W-1:0] stallData;

    vecs[0] = '{PORT_CAM,  25'h0000008, {32{8'hA5}},        '0,                  1, 1'b1, 2};
    vecs[1] = '{PORT_DISP, 25'h0001000, '0,                 256'h1234,           5, 1'b0, 7};
    vecs[2] = '{PORT_HDR,  25'h00ABCDE, '0,                 {8{32'hDEADBEEF}},   1, 1'b0, 3};
    vecs[3] = '{PORT_CAM,  25'h1FFFFFF, {8{32'h01234567}},  '0,                  1, 1'b1, 2};
    vecs[4] = '{PORT_DISP, 25'h0000000, '0,                 '1,                  2, 1'b0, 4};

    rst_n_133M   = 1'b0;
    cam_wr_req   = 1'b0;
    cam_address  = '0;
    cam_data     = '0;
    disp_rd_req  = 1'b0;
    disp_address = '0;
    hdr_rd_req   = 1'b0;
    hdr_address  = '0;
    mem_ready    = 1'b1;

    repeat (3) @(negedge clk_133M);
    checkOutput("reset_cmd_valid", mem_cmd_valid, 1'b0);
    checkOutput("reset_busy", {cam_busy, disp_busy, hdr_busy}, 3'b000);
    checkOutput("reset_flags", {overflow, rd_timeout}, 4'b0000);
    checkOutput("reset_strobes", {disp_data_valid, hdr_data_valid}, 2'b00);
    checkOutput("reset_mem_address", mem_address, '0);
    @(posedge clk_133M);
    #1;
    rst_n_133M = 1'b1;
    @(posedge clk_133M);
    #1;

    $display("[TB] simultaneous requests: display, camera, HDR order");
    respLat = 1;
    applyStimulus(3'b111, 25'h10, {16{16'hC0DE}}, 25'h20, 25'h30);
    pushCmd(1'b0, 25'h20, '0, 256'h1111);
    pushCmd(1'b1, 25'h10, {16{16'hC0DE}}, '0);
    pushCmd(1'b0, 25'h30, '0, 256'h3333);
    dispQ.push_back(256'h1111);
    hdrQ.push_back(256'h3333);
    waitIdle("all_three_idle", 40);

    $display("[TB] display burst cap");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b010, '0, '0, 25'(32'h100 + k), '0);
      pushCmd(1'b0, 25'(32'h100 + k), '0, 256'(32'hB000 + k));
      dispQ.push_back(256'(32'hB000 + k));
      waitIdle("burst_disp_idle", 20);
    end
    applyStimulus(3'b011, 25'h200, {8{32'hCAFEF00D}}, 25'h201, '0);
    pushCmd(1'b1, 25'h200, {8{32'hCAFEF00D}}, '0);
    pushCmd(1'b0, 25'h201, '0, 256'hD201);
    dispQ.push_back(256'hD201);
    waitIdle("burst_cap_idle", 30);
    applyStimulus(3'b110, '0, '0, 25'h300, 25'h301);
    pushCmd(1'b0, 25'h300, '0, 256'hD300);
    pushCmd(1'b0, 25'h301, '0, 256'hE301);
    dispQ.push_back(256'hD300);
    hdrQ.push_back(256'hE301);
    waitIdle("burst_reset_idle", 30);

    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) begin
      respLat = vecs[i].lat;
      applyStimulus(3'(1 << vecs[i].port), vecs[i].addr, vecs[i].wdata,
                    vecs[i].addr, vecs[i].addr);
      pushCmd(vecs[i].expWe, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);
      if (vecs[i].port == PORT_DISP) dispQ.push_back(vecs[i].rdata);
      if (vecs[i].port == PORT_HDR) hdrQ.push_back(vecs[i].rdata);
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk_133M);
        if (busyOf(vecs[i].port)) cnt++;
        else break;
      end
      checkOutput("busy_cycles", cnt, vecs[i].expBusy);
      waitIdle("vector_idle", 20);
    end

    $display("[TB] controller stall with dropped camera pulse");
    checkOutput("overflow_before_stall", overflow, 3'b000);
    stallData = {4{64'h0F1E2D3C4B5A6978}};
    mem_ready = 1'b0;
    applyStimulus(3'b001, 25'h155, stallData, '0, '0);
    pushCmd(1'b1, 25'h155, stallData, '0);
    cnt = 0;
    do begin
      @(negedge clk_133M);
      cnt++;
    end while (!mem_cmd_valid && cnt < 10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_133M);
      checkOutput("stall_valid", {mem_cmd_valid, mem_cmd_we}, 2'b11);
      checkOutput("stall_addr", mem_address, 25'h155);
      checkOutput("stall_wdata", mem_wdata, stallData);
      if (i == 2) begin
        cam_wr_req  = 1'b1;
        cam_address = 25'h0AA;
        cam_data    = ~stallData;
      end
      if (i == 3) cam_wr_req = 1'b0;
    end
    checkOutput("overflow_cam", overflow, 3'b001);
    @(posedge clk_133M);
    #1;
    mem_ready = 1'b1;
    waitIdle("stall_idle", 20);

    $display("[TB] read timeout");
    respEnable = 1'b0;
    applyStimulus(3'b010, '0, '0, 25'h2222, '0);
    pushCmd(1'b0, 25'h2222, '0, '0);
    waitHandshake("timeout_handshake", 20);
    @(posedge clk_133M);
    #1;
    applyStimulus(3'b001, 25'h333, {8{32'h5555AAAA}}, '0, '0);
    pushCmd(1'b1, 25'h333, {8{32'h5555AAAA}}, '0);
    repeat (254) @(negedge clk_133M);
    checkOutput("timeout_not_yet", {rd_timeout, disp_busy, cam_busy}, 3'b011);
    @(negedge clk_133M);
    checkOutput("timeout_fired", {rd_timeout, disp_busy, cam_busy}, 3'b101);
    @(negedge clk_133M);
    checkOutput("timeout_next_served", {mem_cmd_valid, mem_cmd_we}, 2'b11);
    @(posedge clk_133M);
    #1;
    waitIdle("timeout_idle", 20);
    respEnable = 1'b1;

    $display("[TB] reset during read wait");
    respLat = 6;
    applyStimulus(3'b100, '0, '0, '0, 25'h444);
    pushCmd(1'b0, 25'h444, '0, {8{32'h77778888}});
    waitHandshake("reset_test_handshake", 20);
    strobesBefore = hdrStrobes;
    @(posedge clk_133M);
    #1;
    @(posedge clk_133M);
    #3;
    rst_n_133M = 1'b0;
    #1;
    checkOutput("async_reset_cmd", {mem_cmd_valid, mem_cmd_we}, 2'b00);
    checkOutput("async_reset_busy", {cam_busy, disp_busy, hdr_busy}, 3'b000);
    checkOutput("async_reset_flags", {overflow, rd_timeout}, 4'b0000);
    checkOutput("async_reset_disp_data", disp_data, '0);
    checkOutput("async_reset_hdr_data", hdr_data, '0);
    @(posedge clk_133M);
    #1;
    rst_n_133M = 1'b1;
    repeat (10) @(negedge clk_133M);
    checkOutput("late_rdata_no_strobe", hdrStrobes, strobesBefore);
    checkOutput("late_rdata_ignored", hdr_data, '0);
    checkOutput("late_rdata_idle", {hdr_busy, mem_cmd_valid}, 2'b00);

    checkOutput("cmdq_drained", cmdQ.size(), 0);
    checkOutput("dispq_drained", dispQ.size(), 0);
    checkOutput("hdrq_drained", hdrQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
